johnson_ring_decoder: RTL and testbench

- Receive-side companion to the 4-bit ring/Johnson counter.
- Samples a ring code and a twisted-ring (Johnson) code and decodes each to a binary index.
- Flags illegal codes, checks that successive samples advance by exactly one step, and runs a lock FSM with a saturating error counter.
- Sits downstream of the counter, e.g. for sequence monitoring or display drive.

---
 rtl/johnson_ring_pkg.sv | 22 ++
 rtl/johnson_code_decode.sv | 36 +++
 rtl/johnson_ring_decoder.sv | 146 ++++++++++++++
 tb/tb_johnson_ring_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/johnson_ring_pkg.sv
// Shared types and width helpers for the Johnson/ring code receiver.
package johnson_ring_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int N_DEFAULT = 4;
    localparam int JW = $clog2(2 * N_DEFAULT);
    localparam int RW = $clog2(N_DEFAULT);

    function automatic int jw_of(input int n);
        return $clog2(2 * n);
    endfunction

    function automatic int rw_of(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson (twisted-ring) code to binary index decoder with legality flag.
module johnson_code_decode
    import johnson_ring_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = JW
) (
    input  logic [N-1:0]  jc,
    output logic [IW-1:0] idx,
    output logic          legal
);

    int           w_pc;
    logic [N-1:0] w_low_mask;
    logic [N-1:0] w_high_mask;

    always_comb begin
        w_pc = 0;
        for (int i = 0; i < N; i++) begin
            w_pc = w_pc + int'(jc[i]);
        end
        // Legal codes are a run of ones anchored at bit 0 (filling) or at bit N-1 (draining)
        for (int i = 0; i < N; i++) begin
            w_low_mask[i]  = (i < w_pc);
            w_high_mask[i] = (i >= (N - w_pc));
        end
        if (!jc[N-1]) begin
            legal = (jc == w_low_mask);
            idx   = IW'(w_pc);
        end else begin
            legal = (jc == w_high_mask);
            idx   = IW'(2 * N - w_pc);
        end
    end

endmodule

// File: rtl/johnson_ring_decoder.sv
// Decodes sampled Johnson and ring codes, checks single-step advance and tracks lock
// with a saturating error counter.
module johnson_ring_decoder
    import johnson_ring_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 0,
    parameter int ERR_W      = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic [N-1:0]            jc_in,
    input  logic [N-1:0]            rc_in,
    output logic [$clog2(2*N)-1:0]  j_idx,
    output logic [$clog2(N)-1:0]    r_idx,
    output logic                    j_valid,
    output logic                    r_valid,
    output logic                    locked,
    output logic                    step_err,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int JIW = jw_of(N);
    localparam int RIW = rw_of(N);

    state_t           r_state;
    logic [3:0]       r_good;
    logic [JIW-1:0]   r_ref_j;
    logic [RIW-1:0]   r_ref_r;
    logic [JIW-1:0]   r_j_idx;
    logic [RIW-1:0]   r_r_idx;
    logic             r_j_valid;
    logic             r_r_valid;
    logic             r_step_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [JIW-1:0]   w_j_idx;
    logic             w_j_legal;
    logic [RIW-1:0]   w_r_idx;
    logic             w_r_legal;
    int               w_r_ones;
    logic [JIW-1:0]   w_j_next;
    logic [RIW-1:0]   w_r_next;
    logic             w_both;
    logic             w_good;
    logic             w_stall;
    logic             w_hold_ok;

    johnson_code_decode #(
        .N  (N),
        .IW (JIW)
    ) u_jdec (
        .jc    (jc_in),
        .idx   (w_j_idx),
        .legal (w_j_legal)
    );

    always_comb begin
        w_r_ones = 0;
        w_r_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (rc_in[i]) begin
                w_r_ones = w_r_ones + 1;
                w_r_idx  = RIW'(i);
            end
        end
        w_r_legal = (w_r_ones == 1);
    end

    // Expected successors wrap explicitly so non-power-of-two state counts also work
    assign w_j_next  = (r_ref_j == JIW'(2 * N - 1)) ? '0 : r_ref_j + JIW'(1);
    assign w_r_next  = (r_ref_r == RIW'(N - 1)) ? '0 : r_ref_r + RIW'(1);
    assign w_both    = w_j_legal & w_r_legal;
    assign w_good    = w_both & (w_j_idx == w_j_next) & (w_r_idx == w_r_next);
    assign w_stall   = w_both & (w_j_idx == r_ref_j) & (w_r_idx == r_ref_r);
    assign w_hold_ok = w_stall & (ALLOW_HOLD != 0);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= SEARCH;
            r_good     <= '0;
            r_ref_j    <= '0;
            r_ref_r    <= '0;
            r_j_idx    <= '0;
            r_r_idx    <= '0;
            r_j_valid  <= 1'b0;
            r_r_valid  <= 1'b0;
            r_step_err <= 1'b0;
            r_err_cnt  <= '0;
        end else if (en) begin
            r_j_valid  <= w_j_legal;
            r_r_valid  <= w_r_legal;
            r_step_err <= 1'b0;
            if (w_j_legal) r_j_idx <= w_j_idx;
            if (w_r_legal) r_r_idx <= w_r_idx;
            if (w_both) begin
                r_ref_j <= w_j_idx;
                r_ref_r <= w_r_idx;
            end
            case (r_state)
                SEARCH: begin
                    if (w_both) begin
                        r_state <= TRACK;
                        r_good  <= '0;
                    end
                end
                TRACK: begin
                    if (!w_both) begin
                        r_state <= SEARCH;
                        r_good  <= '0;
                    end else if (w_good) begin
                        r_good <= r_good + 4'd1;
                        if (r_good + 4'd1 == 4'(LOCK_CNT)) r_state <= LOCKED;
                    end else if (!w_hold_ok) begin
                        r_good <= '0;
                    end
                end
                LOCKED: begin
                    if (!(w_good || w_hold_ok)) begin
                        r_step_err <= 1'b1;
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                        r_good  <= '0;
                        r_state <= w_both ? TRACK : SEARCH;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    r_good  <= '0;
                end
            endcase
        end else begin
            r_step_err <= 1'b0;
        end
    end

    assign j_idx    = r_j_idx;
    assign r_idx    = r_r_idx;
    assign j_valid  = r_j_valid;
    assign r_valid  = r_r_valid;
    assign locked   = (r_state == LOCKED);
    assign step_err = r_step_err;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_johnson_ring_decoder.sv
// Scoreboard bench: three decoder instances (default, stall-tolerant, 2-bit error counter)
// share code inputs; each vector enables one instance and queues its expected outputs.
module tb_johnson_ring_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [3:0] jc_in = 4'b0000, rc_in = 4'b0000;

    logic [2:0] d0_j, d1_j, d2_j;
    logic [1:0] d0_r, d1_r, d2_r;
    logic       d0_jv, d1_jv, d2_jv, d0_rv, d1_rv, d2_rv;
    logic       d0_lk, d1_lk, d2_lk, d0_se, d1_se, d2_se;
    logic [7:0] d0_ec, d1_ec;
    logic [1:0] d2_ec;

    johnson_ring_decoder #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0), .ERR_W(8)) u_dut0 (
        .clk(clk), .clr(clr), .en(en0), .jc_in(jc_in), .rc_in(rc_in),
        .j_idx(d0_j), .r_idx(d0_r), .j_valid(d0_jv), .r_valid(d0_rv),
        .locked(d0_lk), .step_err(d0_se), .err_cnt(d0_ec));

    johnson_ring_decoder #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .clr(clr), .en(en1), .jc_in(jc_in), .rc_in(rc_in),
        .j_idx(d1_j), .r_idx(d1_r), .j_valid(d1_jv), .r_valid(d1_rv),
        .locked(d1_lk), .step_err(d1_se), .err_cnt(d1_ec));

    johnson_ring_decoder #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0), .ERR_W(2)) u_dut2 (
        .clk(clk), .clr(clr), .en(en2), .jc_in(jc_in), .rc_in(rc_in),
        .j_idx(d2_j), .r_idx(d2_r), .j_valid(d2_jv), .r_valid(d2_rv),
        .locked(d2_lk), .step_err(d2_se), .err_cnt(d2_ec));

    typedef struct {
        string       nm;
        int          d;
        int          due;
        logic [16:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t m;
    logic [16:0] act;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [3:0] jt [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] rt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] pack(input int j, input int r, input logic jv, input logic rv,
                                         input logic lk, input logic se, input int ec);
        return {3'(j), 2'(r), jv, rv, lk, se, 8'(ec)};
    endfunction

    function automatic string show(input logic [16:0] v);
        return $sformatf("j=%0d r=%0d jv=%0b rv=%0b lk=%0b se=%0b ec=%0d",
                         v[16:14], v[13:12], v[11], v[10], v[9], v[8], v[7:0]);
    endfunction

    // Monitor: compares the enabled instance's outputs one edge after its sample
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            m = q.pop_front();
            case (m.d)
                0:       act = {d0_j, d0_r, d0_jv, d0_rv, d0_lk, d0_se, d0_ec};
                1:       act = {d1_j, d1_r, d1_jv, d1_rv, d1_lk, d1_se, d1_ec};
                default: act = {d2_j, d2_r, d2_jv, d2_rv, d2_lk, d2_se, 6'b0, d2_ec};
            endcase
            checks = checks + 1;
            if (act !== m.exp) begin
                errors = errors + 1;
                $display("FAIL %s (dut%0d): got %s, expected %s", m.nm, m.d, show(act), show(m.exp));
            end
        end
    end

    task automatic vec(input string nm, input int d, input logic c, input logic e,
                       input logic [3:0] jc, input logic [3:0] rc,
                       input int j, input int r, input logic jv, input logic rv,
                       input logic lk, input logic se, input int ec);
        exp_t x;
        @(posedge clk);
        #1;
        clr   = c;
        en0   = e && (d == 0);
        en1   = e && (d == 1);
        en2   = e && (d == 2);
        jc_in = jc;
        rc_in = rc;
        x.nm  = nm;
        x.d   = d;
        x.due = cyc + 1;
        x.exp = pack(j, r, jv, rv, lk, se, ec);
        q.push_back(x);
    endtask

    // Legal sample k of the clean sequence: Johnson index k mod 8, ring index k mod 4
    task automatic gd(input string nm, input int d, input int k,
                      input logic lk, input logic se, input int ec);
        vec(nm, d, 1'b0, 1'b1, jt[k % 8], rt[k % 4], k % 8, k % 4, 1'b1, 1'b1, lk, se, ec);
    endtask

    initial begin
        int k;
        int ec;

        vec("rst0", 0, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        vec("rst1", 0, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        vec("hold_a", 0, 1'b0, 1'b0, 4'b0011, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
        vec("hold_b", 0, 1'b0, 1'b0, 4'b0011, 4'b0100, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i <= 8; i++) gd("lock_wrap", 0, i, i >= 3, 1'b0, 0);

        vec("illegal_j", 0, 1'b0, 1'b1, 4'b0101, 4'b0010, 0, 1, 0, 1, 0, 1, 1);
        vec("illegal_r", 0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1, 1, 1, 0, 0, 0, 1);
        for (int i = 2; i <= 5; i++) gd("relock1", 0, i, i == 5, 1'b0, 1);
        for (int i = 6; i <= 10; i++) gd("locked_run", 0, i, 1'b1, 1'b0, 1);

        vec("skip", 0, 1'b0, 1'b1, 4'b1111, 4'b1000, 4, 3, 1, 1, 0, 1, 2);
        vec("relock2_a", 0, 1'b0, 1'b1, 4'b1110, 4'b0001, 5, 0, 1, 1, 0, 0, 2);
        vec("relock2_b", 0, 1'b0, 1'b1, 4'b1100, 4'b0010, 6, 1, 1, 1, 0, 0, 2);
        vec("relock2_c", 0, 1'b0, 1'b1, 4'b1000, 4'b0100, 7, 2, 1, 1, 1, 0, 2);
        vec("stall_err", 0, 1'b0, 1'b1, 4'b1000, 4'b0100, 7, 2, 1, 1, 0, 1, 3);
        vec("en_low", 0, 1'b0, 1'b0, 4'b0101, 4'b1111, 7, 2, 1, 1, 0, 0, 3);
        vec("relock3_a", 0, 1'b0, 1'b1, 4'b0000, 4'b1000, 0, 3, 1, 1, 0, 0, 3);
        vec("relock3_b", 0, 1'b0, 1'b1, 4'b0001, 4'b0001, 1, 0, 1, 1, 0, 0, 3);
        vec("relock3_c", 0, 1'b0, 1'b1, 4'b0011, 4'b0010, 2, 1, 1, 1, 1, 0, 3);
        vec("clr_vs_err", 0, 1'b1, 1'b1, 4'b1111, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
        gd("after_clr", 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i <= 3; i++) gd("h_lock", 1, i, i == 3, 1'b0, 0);
        gd("h_stall_locked", 1, 3, 1'b1, 1'b0, 0);
        gd("h_step", 1, 4, 1'b1, 1'b0, 0);
        gd("h_jump", 1, 0, 1'b0, 1'b1, 1);
        gd("h_stall_track", 1, 0, 1'b0, 1'b0, 1);
        gd("h_relock_a", 1, 1, 1'b0, 1'b0, 1);
        gd("h_relock_b", 1, 2, 1'b0, 1'b0, 1);
        gd("h_relock_c", 1, 3, 1'b1, 1'b0, 1);

        for (int i = 0; i <= 3; i++) gd("s_lock", 2, i, i == 3, 1'b0, 0);
        k = 3;
        for (int e = 1; e <= 5; e++) begin
            ec = (e > 3) ? 3 : e;
            gd("s_err", 2, k, 1'b0, 1'b1, ec);
            for (int s = 1; s <= 3; s++) begin
                k = k + 1;
                gd("s_relock", 2, k, s == 3, 1'b0, ec);
            end
        end
        vec("s_clr", 2, 1'b1, 1'b1, jt[k % 8], rt[k % 4], 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        clr = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
